lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit sitting directly upstream of the 64 KiB BRAM memory block.
- Accepts byte/halfword/word load and store requests from the core execute stage.
- Converts each request into word-aligned memory transactions and waits on the memory ready handshake.
- Returns sign- or zero-extended load data; a read-modify-write sequence implements sub-word stores, since the memory has no byte enables.

Parameters:
- MEM_BYTES, 65536, addressable memory size; byte addresses >= MEM_BYTES are range errors.
- TIMEOUT, 16, maximum cycles to wait for mem_ready_i per memory access before flagging an error.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  core request strobe; sampled only when busy_o=0.
- we_i  in  1  1=store, 0=load.
- size_i  in  2  00=byte, 01=half, 10=word, 11=illegal.
- unsigned_i  in  1  1=zero-extend load result, 0=sign-extend.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- busy_o  out  1  request in progress; req_i ignored.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o: misaligned, illegal size, out of range, or timeout.
- rdata_o  out  32  extended load result; held until next done_o.
- mem_re_o  out  1  memory read request; held until mem_ready_i.
- mem_we_o  out  1  memory write request; held until mem_ready_i.
- mem_addr_o  out  32  {addr[31:2],2'b00}.
- mem_wdata_o  out  32  full word to write.
- mem_rdata_i  in  32  memory read data; valid when mem_ready_i=1.
- mem_ready_i  in  1  access complete.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, timeout counter 0. Outstanding memory access is abandoned immediately.
- FSM states: IDLE, RD, MERGE, WR, DONE.
- IDLE, on req_i=1: latch all request fields; busy_o=1 from the next cycle.
- Error checks at accept time:
  - Illegal if size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr >= MEM_BYTES.
  - Illegal request -> DONE with err=1; no memory access is issued.
- Legal request -> next state:
  - load -> RD.
  - word store -> WR.
  - byte/half store -> RD.
- RD: mem_re_o=1. On mem_ready_i=1, capture mem_rdata_i.
  - load -> DONE.
  - sub-word store -> MERGE.
- MERGE (1 cycle): replace the target lane(s) selected by addr[1:0] in the captured word with wdata[7:0] or wdata[15:0]; go to WR.
- WR: mem_we_o=1 with mem_wdata_o stable. On mem_ready_i=1 -> DONE.
- DONE:
  - done_o=1 and busy_o=0; rdata_o updated for loads only, unchanged for stores and errors.
  - req_i in this cycle is accepted (back-to-back); otherwise -> IDLE.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Bit 7 or bit 15 extends to 32 unless unsigned_i=1.
- Memory strobes: mem_re_o and mem_we_o are never both 1; both are low in IDLE, MERGE and DONE.
- Timeout counter:
  - Clears on entry to RD/WR and increments each cycle mem_ready_i=0.
  - On reaching TIMEOUT: drop strobe -> DONE with err=1; a store performs no write.
- Latency, with mem_ready_i high in the first cycle of each access:
  - load: done_o 2 cycles after accept.
  - word store: 2 cycles.
  - sub-word store: 4 cycles.
  - error: 1 cycle.
- mem_ready_i while no strobe is active: ignored.

Decomposition:
- Package lsu_pkg:
  - size_t enum (SZ_B, SZ_H, SZ_W).
  - lsu_state_t enum.
  - MEM_BYTES default constant.
- Sub-module lsu_align (combinational): load extract/extend and store lane merge, shared by DONE and MERGE paths.

Test Plan:
- Memory word 0x0000_0100 = 0x8844_22F1; LB addr 0x103 -> rdata_o=0xFFFF_FF88, err_o=0, done_o at accept+2.
- Same word; LHU addr 0x102 -> rdata_o=0x0000_8844; LH addr 0x100 -> rdata_o=0x0000_22F1.
- SB addr 0x101 wdata 0xAB -> one read, then write 0x8844_ABF1 to 0x100; done_o at accept+4. Follow-up LW addr 0x100 -> 0x8844_ABF1.
- LW addr 0x102, SH addr 0x001, LW addr 0x10000 -> each done_o+err_o at accept+1; mem_re_o/mem_we_o never asserted.
- mem_ready_i held 0 with TIMEOUT=16 on SW -> mem_we_o high 16 cycles, then done_o+err_o; no write committed.
- rst_ni pulled low during WR of SB -> outputs 0 asynchronously; after release a new LW completes normally with correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 65536;
  localparam int unsigned TIMEOUT_DEFAULT   = 16;

  // Access width; encoding 2'b11 has no member and is rejected at accept.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts and extends a load result from a word, and merges
// sub-word store data into a word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_t       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_B:    load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_H:    load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Overwrite only the targeted lane(s); other bytes keep memory contents.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_B: merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_H: begin
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a word-wide memory without byte enables.
// Sub-word stores are done as read, merge, write.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t    state_q, state_d;
  logic          we_q, we_d;
  size_t         size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_bad;
  logic          load_done;
  logic [31:0]   load_word;
  logic [31:0]   merge_word;

  // One steering block serves both the DONE extract and the MERGE step.
  lsu_align u_align (
    .word_i     (data_q),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_word),
    .merge_o    (merge_word)
  );

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    case (size_i)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = addr_i[0];
      2'b10:   req_bad = |addr_i[1:0];
      default: req_bad = 1'b1;
    endcase
    if (addr_i >= MEM_BYTES) req_bad = 1'b1;
  end

  assign load_done = (state_q == ST_DONE) && !we_q && !err_q;

  // Next-state, request latch, memory data path and timeout counter.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    rdata_d = load_done ? load_word : rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_t'(size_i);
          uns_d   = unsigned_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
          err_d   = req_bad;
          if (req_bad) begin
            state_d = ST_DONE;
          end else if (we_i && size_i == 2'b10) begin
            // Full-word store needs no read-back.
            data_d  = wdata_i;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (mem_ready_i) begin
          data_d  = mem_rdata_i;
          state_d = we_q ? ST_MERGE : ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_MERGE: begin
        data_d  = merge_word;
        cnt_d   = '0;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (mem_ready_i) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any outstanding access at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = (state_q == ST_RD) || (state_q == ST_MERGE) || (state_q == ST_WR);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_DONE) && err_q;
  assign rdata_o     = load_done ? load_word : rdata_q;
  assign mem_re_o    = (state_q == ST_RD);
  assign mem_we_o    = (state_q == ST_WR);
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = data_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases then randomized traffic
// against a byte-array reference memory.
module tb_lsu;

  localparam int TO = 16;

  logic        clk_i, rst_ni, req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, err_o, mem_re_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  lsu dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .we_i        (we_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // 0 = ready on first cycle, 1 = random 0..3 wait, 2 = never ready,
  // 3 = reads ready at once, writes never.
  int ready_mode = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'h8844_22F1;
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory slave: responds on the falling edge, commits a write one edge later.
  logic [31:0] mem [0:16383];
  initial begin : mem_model
    int lat, target;
    logic give, pend;
    logic [13:0] pend_idx;
    logic [31:0] pend_data;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < 16384; i++) mem[i] = init_word(i);
    lat = 0; target = 0; pend = 1'b0; pend_idx = '0; pend_data = '0;
    forever begin
      @(negedge clk_i);
      if (pend && rst_ni) mem[pend_idx] = pend_data;
      pend = 1'b0;
      if (!rst_ni) begin
        mem_ready_i = 1'b0;
        lat = 0;
      end else if (mem_re_o || mem_we_o) begin
        if (lat == 0) target = (ready_mode == 1) ? int'($urandom_range(0, 3)) : 0;
        if (ready_mode <= 1) give = (lat >= target);
        else give = (ready_mode == 3) && mem_re_o;
        if (give) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem_re_o ? mem[mem_addr_o[15:2]] : $urandom;
          if (mem_we_o) begin
            pend = 1'b1;
            pend_idx = mem_addr_o[15:2];
            pend_data = mem_wdata_o;
          end
          lat = 0;
        end else begin
          mem_ready_i = 1'b0;
          lat++;
        end
      end else begin
        // Stray ready pulses while no strobe is up must be ignored.
        mem_ready_i = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata_i = $urandom;
        lat = 0;
      end
    end
  end

  // Reference: little-endian byte array plus last expected load result.
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] exp_rdata;

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                            input logic [31:0] a);
    longint v;
    int n;
    logic [15:0] idx;
    n = nbytes(size);
    v = 0;
    for (int k = 0; k < n; k++) begin
      idx = a[15:0] + 16'(k);
      v += longint'(ref_mem[idx]) << (8 * k);
    end
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Issue one request at a falling edge with the DUT able to accept, and
  // check completion, latency, strobes and result against the reference.
  task automatic run_txn(input int mode, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic illegal, exp_err;
    int exp_lat, lat, re_cnt, we_cnt, both, exp_re, exp_we;
    logic [15:0] idx;
    ready_mode = mode;
    illegal = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd65536);
    exp_err = illegal || (mode == 2);
    if (illegal) exp_lat = 1;
    else if (mode == 2) exp_lat = TO + 1;
    else if (!we || size == 2'd2) exp_lat = 2;
    else exp_lat = 4;
    if (illegal) begin exp_re = 0; exp_we = 0; end
    else begin
      exp_re = (!we || size != 2'd2) ? 1 : 0;
      exp_we = we ? 1 : 0;
      if (mode == 2) begin
        exp_re = exp_re * TO;
        exp_we = (we && size == 2'd2) ? TO : 0;
      end
    end
    req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    we_i = $urandom; size_i = $urandom; addr_i = $urandom; wdata_i = $urandom;
    check("busy_after_accept", 32'(busy_o), 32'(!illegal));
    lat = 0; re_cnt = 0; we_cnt = 0; both = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk_i); @(negedge clk_i); end
      if (mem_re_o) re_cnt++;
      if (mem_we_o) we_cnt++;
      if (mem_re_o && mem_we_o) both++;
      if (done_o) begin lat = c; break; end
    end
    check("done_seen", 32'(lat != 0), 32'd1);
    if (mode == 1 && !illegal) check("latency_min", 32'(lat >= exp_lat), 32'd1);
    else check("latency", lat, exp_lat);
    check("strobe_overlap", both, 0);
    if (mode != 1) begin
      check("re_cycles", re_cnt, exp_re);
      check("we_cycles", we_cnt, exp_we);
    end
    check("err", 32'(err_o), 32'(exp_err));
    if (!exp_err) begin
      if (!we) exp_rdata = ref_load(size, uns, addr);
      else begin
        for (int k = 0; k < nbytes(size); k++) begin
          idx = addr[15:0] + 16'(k);
          ref_mem[idx] = wdata[8*k +: 8];
        end
      end
    end
    check("rdata", rdata_o, exp_rdata);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  initial begin : main
    logic [1:0] sz;
    logic [31:0] a;
    int r, mode;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = '0; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    exp_rdata = '0;
    for (int i = 0; i < 16384; i++) begin
      a = init_word(i);
      for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = a[8*k +: 8];
    end
    repeat (3) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_re", 32'(mem_re_o), 0);
    check("rst_we", 32'(mem_we_o), 0);
    check("rst_rdata", rdata_o, 0);
    rst_ni = 1'b1;
    idle_cycles(2);

    // Directed loads on word 0x100 = 0x884422F1.
    run_txn(0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    check("lb_103", rdata_o, 32'hFFFF_FF88);
    run_txn(0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    check("lhu_102", rdata_o, 32'h0000_8844);
    run_txn(0, 1'b0, 2'd1, 1'b0, 32'h100, 32'h0);
    check("lh_100", rdata_o, 32'h0000_22F1);
    // Byte store via read-modify-write, then read back.
    run_txn(0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB);
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("lw_after_sb", rdata_o, 32'h8844_ABF1);
    // Accept-time errors.
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    run_txn(0, 1'b1, 2'd1, 1'b0, 32'h001, 32'h1234);
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h10000, 32'h0);
    run_txn(0, 1'b0, 2'd3, 1'b0, 32'h200, 32'h0);
    // Word store that never gets ready: times out, commits nothing.
    run_txn(2, 1'b1, 2'd2, 1'b0, 32'h104, 32'hDEAD_BEEF);
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);

    // Reset while a byte store is stuck in its write phase.
    idle_cycles(1);
    ready_mode = 3;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; unsigned_i = 1'b0;
    addr_i = 32'h102; wdata_i = 32'h5C;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    r = 0;
    for (int c = 0; c < 10 && !mem_we_o; c++) begin
      @(posedge clk_i); @(negedge clk_i);
      r = c;
    end
    check("rmw_reached_write", 32'(mem_we_o), 32'd1);
    idle_cycles(2);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 0);
    check("arst_done", 32'(done_o), 0);
    check("arst_err", 32'(err_o), 0);
    check("arst_re", 32'(mem_re_o), 0);
    check("arst_we", 32'(mem_we_o), 0);
    check("arst_rdata", rdata_o, 0);
    check("arst_addr", mem_addr_o, 0);
    check("arst_wdata", mem_wdata_o, 0);
    exp_rdata = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_cycles(1);
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("lw_after_reset", rdata_o, 32'h8844_ABF1);

    // Randomized traffic, sometimes back-to-back from the DONE cycle.
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 19);
      mode = (r == 0) ? 2 : (r < 10) ? 1 : 0;
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 19);
      if (r < 16) a = 32'h100 + 32'($urandom_range(0, 31));
      else if (r < 18) a = 32'($urandom_range(0, 65535));
      else a = 32'h0000_FFF0 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_txn(mode, 1'($urandom), sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
